id_stage_pipe: RTL and testbench



---
 rtl/id_stage_pipe_pkg.sv | 29 ++
 rtl/id_regfile.sv | 39 +++
 rtl/id_stage_pipe.sv | 95 +++++++++
 tb/tb_id_stage_pipe.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pipe_pkg.sv
// Shared defaults, instruction field offsets and sign-extension helper for the
// decode stage and its register file.
package id_stage_pipe_pkg;

  localparam int DEFAULT_DATA_W     = 8;
  localparam int DEFAULT_REG_ADDR_W = 3;
  localparam int DEFAULT_INSTR_W    = 8;

  // rs1 and the immediate share the low field; rs2/rd sits directly above it.
  function automatic int rs1_lsb(input int reg_addr_w);
    rs1_lsb = 0 * reg_addr_w;
  endfunction

  function automatic int rd_lsb(input int reg_addr_w);
    rd_lsb = reg_addr_w;
  endfunction

  // Bits at or above field_w are filled with sign; caller slices to its width.
  function automatic logic [31:0] sign_extend(input logic [31:0] field,
                                              input logic        sign,
                                              input int          field_w);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = (i < field_w) ? field[i] : sign;
    end
    sign_extend = r;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// Register file: synchronous reset, one write port, two combinational read
// ports that return the write-back data when the addresses collide.
module id_regfile
  import id_stage_pipe_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [REG_ADDR_W-1:0] raddr1,
  input  logic [REG_ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0]     rdata1,
  output logic [DATA_W-1:0]     rdata2
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = (we && (waddr == raddr1)) ? wdata : regs[raddr1];
    rdata2 = (we && (waddr == raddr2)) ? wdata : regs[raddr2];
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Instruction decode stage: field decode, register read with write-back
// bypass, and the ID/EX pipeline register with valid/stall/flush control.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W,
  parameter int INSTR_W    = DEFAULT_INSTR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_valid,
  input  logic [INSTR_W-1:0]    instruction,
  input  logic                  SEtoReg_in,
  input  logic                  WriteReg_in,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  WriteReg,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic [DATA_W-1:0]     write_data,
  output logic                  id_valid,
  output logic                  SEtoReg_out,
  output logic                  WriteReg_out,
  output logic [REG_ADDR_W-1:0] rs1,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic [DATA_W-1:0]     data1,
  output logic [DATA_W-1:0]     data2,
  output logic [DATA_W-1:0]     imm_ext
);

  logic [REG_ADDR_W-1:0] dec_rs1;
  logic [REG_ADDR_W-1:0] dec_rd;
  logic [DATA_W-1:0]     dec_imm;
  logic [DATA_W-1:0]     rd_data1;
  logic [DATA_W-1:0]     rd_data2;
  logic [31:0]           imm_full;

  always_comb begin
    dec_rs1  = instruction[rs1_lsb(REG_ADDR_W) +: REG_ADDR_W];
    dec_rd   = instruction[rd_lsb(REG_ADDR_W) +: REG_ADDR_W];
    imm_full = sign_extend(32'(dec_rs1), dec_rs1[REG_ADDR_W-1], REG_ADDR_W);
    dec_imm  = imm_full[DATA_W-1:0];
  end

  id_regfile #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .we     (WriteReg),
    .waddr  (rd_in),
    .wdata  (write_data),
    .raddr1 (dec_rs1),
    .raddr2 (dec_rd),
    .rdata1 (rd_data1),
    .rdata2 (rd_data2)
  );

  // Flow control: id_valid marks a live ID/EX entry; stall freezes the entry
  // (operands still track write-back to the held registers); flush turns it
  // into a bubble and overrides stall; if_valid=0 without stall loads a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid     <= 1'b0;
      SEtoReg_out  <= 1'b0;
      WriteReg_out <= 1'b0;
      rs1          <= '0;
      rd_out       <= '0;
      data1        <= '0;
      data2        <= '0;
      imm_ext      <= '0;
    end else if (flush) begin
      id_valid     <= 1'b0;
      WriteReg_out <= 1'b0;
    end else if (stall) begin
      if (WriteReg && (rd_in == rs1)) begin
        data1 <= write_data;
      end
      if (WriteReg && (rd_in == rd_out)) begin
        data2 <= write_data;
      end
    end else begin
      id_valid     <= if_valid;
      SEtoReg_out  <= SEtoReg_in;
      WriteReg_out <= WriteReg_in & if_valid;
      rs1          <= dec_rs1;
      rd_out       <= dec_rd;
      data1        <= rd_data1;
      data2        <= rd_data2;
      imm_ext      <= dec_imm;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: reset, read, bypass, sign extension,
// stall refresh, flush and reset priority, with hand-computed expectations.
module tb_id_stage_pipe;

  logic       clk;
  logic       reset;
  logic       if_valid;
  logic [7:0] instruction;
  logic       SEtoReg_in;
  logic       WriteReg_in;
  logic       stall;
  logic       flush;
  logic       WriteReg;
  logic [2:0] rd_in;
  logic [7:0] write_data;
  logic       id_valid;
  logic       SEtoReg_out;
  logic       WriteReg_out;
  logic [2:0] rs1;
  logic [2:0] rd_out;
  logic [7:0] data1;
  logic [7:0] data2;
  logic [7:0] imm_ext;

  int n_checks;
  int n_fail;

  id_stage_pipe #(.DATA_W(8), .REG_ADDR_W(3), .INSTR_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .if_valid     (if_valid),
    .instruction  (instruction),
    .SEtoReg_in   (SEtoReg_in),
    .WriteReg_in  (WriteReg_in),
    .stall        (stall),
    .flush        (flush),
    .WriteReg     (WriteReg),
    .rd_in        (rd_in),
    .write_data   (write_data),
    .id_valid     (id_valid),
    .SEtoReg_out  (SEtoReg_out),
    .WriteReg_out (WriteReg_out),
    .rs1          (rs1),
    .rd_out       (rd_out),
    .data1        (data1),
    .data2        (data2),
    .imm_ext      (imm_ext)
  );

  // Clock block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then sample away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_instr(input logic v, input logic [7:0] ins,
                             input logic se, input logic wr);
    if_valid    = v;
    instruction = ins;
    SEtoReg_in  = se;
    WriteReg_in = wr;
  endtask

  task automatic drive_wb(input logic we, input logic [2:0] addr, input logic [7:0] d);
    WriteReg   = we;
    rd_in      = addr;
    write_data = d;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    drive_instr(1'b1, 8'b00_001_011, 1'b1, 1'b1);
    drive_wb(1'b0, 3'd0, 8'h00);
    #2;
    step();

    // Reset state
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_wr_out",   32'(WriteReg_out), 32'd0);
    check("rst_se_out",   32'(SEtoReg_out), 32'd0);
    check("rst_rs1",      32'(rs1), 32'd0);
    check("rst_data1",    32'(data1), 32'd0);
    check("rst_imm",      32'(imm_ext), 32'd0);

    // Reset then read
    reset = 1'b0;
    step();
    check("rd_id_valid", 32'(id_valid), 32'd1);
    check("rd_rs1",      32'(rs1), 32'd3);
    check("rd_rd_out",   32'(rd_out), 32'd1);
    check("rd_data1",    32'(data1), 32'd0);
    check("rd_data2",    32'(data2), 32'd0);
    check("rd_wr_out",   32'(WriteReg_out), 32'd1);
    check("rd_se_out",   32'(SEtoReg_out), 32'd1);
    check("rd_imm",      32'(imm_ext), 32'h03);

    // Write reg5 while a bubble loads
    drive_wb(1'b1, 3'd5, 8'h10);
    drive_instr(1'b0, 8'h00, 1'b0, 1'b1);
    step();
    check("bub_id_valid", 32'(id_valid), 32'd0);
    check("bub_wr_out",   32'(WriteReg_out), 32'd0);

    drive_wb(1'b0, 3'd0, 8'h00);
    drive_instr(1'b1, 8'b00_000_101, 1'b0, 1'b0);
    step();
    check("wr_data1", 32'(data1), 32'h10);
    check("wr_data2", 32'(data2), 32'h00);
    check("wr_imm",   32'(imm_ext), 32'hFD);

    // Same-cycle bypass on both ports
    drive_wb(1'b1, 3'd3, 8'h20);
    drive_instr(1'b1, 8'b00_011_011, 1'b0, 1'b0);
    step();
    check("byp_data1", 32'(data1), 32'h20);
    check("byp_data2", 32'(data2), 32'h20);

    // Sign extension of a negative field
    drive_wb(1'b0, 3'd0, 8'h00);
    drive_instr(1'b1, 8'b11_000_110, 1'b1, 1'b0);
    step();
    check("sx_imm",    32'(imm_ext), 32'hFE);
    check("sx_rs1",    32'(rs1), 32'd6);
    check("sx_rd_out", 32'(rd_out), 32'd0);

    // Stall refresh
    drive_instr(1'b1, 8'b00_100_010, 1'b0, 1'b1);
    step();
    check("ld_data1", 32'(data1), 32'h00);
    stall = 1'b1;
    drive_wb(1'b1, 3'd2, 8'h55);
    drive_instr(1'b1, 8'b00_111_111, 1'b1, 1'b0);
    step();
    check("st_data1",    32'(data1), 32'h55);
    check("st_data2",    32'(data2), 32'h00);
    check("st_rs1",      32'(rs1), 32'd2);
    check("st_rd_out",   32'(rd_out), 32'd4);
    check("st_id_valid", 32'(id_valid), 32'd1);
    check("st_wr_out",   32'(WriteReg_out), 32'd1);
    check("st_se_out",   32'(SEtoReg_out), 32'd0);
    check("st_imm",      32'(imm_ext), 32'h02);
    drive_wb(1'b1, 3'd4, 8'h66);
    step();
    check("st2_data1", 32'(data1), 32'h55);
    check("st2_data2", 32'(data2), 32'h66);

    // Release stall: next instruction loads from the updated file
    stall = 1'b0;
    drive_wb(1'b0, 3'd0, 8'h00);
    drive_instr(1'b1, 8'b00_010_100, 1'b0, 1'b0);
    step();
    check("rel_data1",  32'(data1), 32'h66);
    check("rel_data2",  32'(data2), 32'h55);
    check("rel_rs1",    32'(rs1), 32'd4);
    check("rel_rd_out", 32'(rd_out), 32'd2);
    check("rel_imm",    32'(imm_ext), 32'hFC);

    // Flush wins over stall
    drive_instr(1'b1, 8'b00_010_100, 1'b0, 1'b1);
    step();
    check("pre_fl_wr_out", 32'(WriteReg_out), 32'd1);
    stall = 1'b1;
    flush = 1'b1;
    step();
    check("fl_id_valid", 32'(id_valid), 32'd0);
    check("fl_wr_out",   32'(WriteReg_out), 32'd0);
    stall = 1'b0;
    flush = 1'b0;

    // Register 0 is writable
    drive_wb(1'b1, 3'd0, 8'h77);
    drive_instr(1'b1, 8'b00_000_000, 1'b0, 1'b0);
    step();
    check("r0_bypass", 32'(data1), 32'h77);
    drive_wb(1'b0, 3'd0, 8'h00);
    step();
    check("r0_stored", 32'(data1), 32'h77);

    // Reset discards a concurrent write-back and clears the file
    reset = 1'b1;
    drive_wb(1'b1, 3'd4, 8'hAA);
    step();
    check("rr_id_valid", 32'(id_valid), 32'd0);
    check("rr_data1",    32'(data1), 32'd0);
    reset = 1'b0;
    drive_wb(1'b0, 3'd0, 8'h00);
    drive_instr(1'b1, 8'b00_101_100, 1'b0, 1'b0);
    step();
    check("rr_reg4", 32'(data1), 32'h00);
    check("rr_reg5", 32'(data2), 32'h00);
    check("rr_valid", 32'(id_valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
